// File: rtl/prescaler_multi_if.sv
// Control and observation bundle for prescaler_multi.
// The master drives the run and divisor controls. The slave returns ticks, divided clocks and the shadow readback.
interface prescaler_multi_if #(
    parameter int NCH = 4,
    parameter int W   = 16
);
    logic [NCH-1:0]   en;
    logic [NCH-1:0]   load;
    logic [W-1:0]     div_in;
    logic             sync;
    logic [NCH-1:0]   tick_out;
    logic [NCH-1:0]   clk_out;
    logic [NCH*W-1:0] div_rd;

    modport master (
        output en, load, div_in, sync,
        input  tick_out, clk_out, div_rd
    );

    modport slave (
        input  en, load, div_in, sync,
        output tick_out, clk_out, div_rd
    );
endinterface

// File: rtl/prescaler_multi.sv
// Multi-channel programmable prescaler. Each channel divides clk_in by div+1 and produces a one-cycle tick and a 50%-duty clock.
// Divisors are double-buffered, so a runtime change takes effect at the next period boundary.
module prescaler_multi #(
    parameter int             NCH     = 4,
    parameter int             W       = 16,
    parameter logic [W-1:0]   DIV_RST = '0
) (
    input  logic              clk_in,
    input  logic              rst_n,
    prescaler_multi_if.slave  bus
);
    logic [W-1:0]   shadow      [NCH];
    logic [W-1:0]   cnt         [NCH];
    logic [W-1:0]   next_shadow [NCH];
    logic [NCH-1:0] tick_q;
    logic [NCH-1:0] clk_q;

    // A load in the same cycle as a reload wins, so load+sync restarts at the new ratio.
    always_comb begin
        // NOTE: every channel is assigned on every pass, so no latch can be inferred here.
        for (int i = 0; i < NCH; i++) begin
            next_shadow[i] = bus.load[i] ? bus.div_in : shadow[i];
        end
    end

    // NOTE: state updates use non-blocking assignments, so all channels sample the same pre-edge values.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the divisor arrays are plain flops, not RAM, so they take the async reset too.
            for (int i = 0; i < NCH; i++) begin
                shadow[i] <= DIV_RST;
                cnt[i]    <= DIV_RST;
            end
            tick_q <= '0;
            clk_q  <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (bus.load[i]) begin
                    shadow[i] <= bus.div_in;
                end
                // Disable and sync share one action: rearm from the divisor and park the outputs low.
                if (!bus.en[i] || bus.sync) begin
                    cnt[i]    <= next_shadow[i];
                    tick_q[i] <= 1'b0;
                    clk_q[i]  <= 1'b0;
                end else if (cnt[i] == '0) begin
                    cnt[i]    <= next_shadow[i];
                    tick_q[i] <= 1'b1;
                    clk_q[i]  <= ~clk_q[i];
                end else begin
                    cnt[i]    <= cnt[i] - 1'b1;
                    tick_q[i] <= 1'b0;
                end
            end
        end
    end

    assign bus.tick_out = tick_q;
    assign bus.clk_out  = clk_q;

    for (genvar g = 0; g < NCH; g++) begin : g_rd
        assign bus.div_rd[g*W +: W] = shadow[g];
    end
endmodule
